adder_sweep_checker: RTL and testbench

Hardware stimulus/response engine for the combinational N-bit ripple adder (`fa4` family). On `start` it drives every `{A, B, Cin}` combination into the adder and compares the adder's `S`/`Cout` against an internally computed reference sum. It counts mismatches and records the first failing vector. It is the driving-and-checking end of the adder's operand/result interface, so the exhaustive sweep can run on-chip without a simulator bench.

---
 rtl/adder_test_pkg.sv | 24 ++
 rtl/sweep_counter.sv | 28 ++
 rtl/adder_sweep_checker.sv | 105 ++++++++++
 tb/tb_adder_sweep_checker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_test_pkg.sv
// Shared types and width helpers for the adder sweep checker.
// Widths are derived from the adder operand width so every user agrees on them.
package adder_test_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } sweep_state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Vector index is {A, B, Cin}.
  function automatic int idx_width(input int width);
    return 2 * width + 1;
  endfunction

  // One bit wider than the index so a full sweep of mismatches never saturates.
  function automatic int err_width(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/sweep_counter.sv
// Vector index counter for the adder sweep: synchronous clear, count enable,
// and a flag that marks the final (all-ones) index.
module sweep_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = &count;

endmodule

// File: rtl/adder_sweep_checker.sv
// Exhaustive on-chip stimulus/response checker for an N-bit ripple adder:
// drives every {A, B, Cin}, compares {Cout, S} to A+B+Cin, logs mismatches.
module adder_sweep_checker
  import adder_test_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  output logic [WIDTH-1:0]      A,
  output logic [WIDTH-1:0]      B,
  output logic                  Cin,
  input  logic [WIDTH-1:0]      S,
  input  logic                  Cout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*WIDTH+1:0]    err_count,
  output logic [2*WIDTH:0]      first_fail
);

  localparam int IW = idx_width(WIDTH);
  localparam int EW = err_width(WIDTH);

  sweep_state_t  state, state_next;
  logic [IW-1:0] idx;
  logic          idx_last;
  logic          launch;
  logic          advance;
  logic [WIDTH:0] ref_sum;
  logic          mismatch;
  logic [EW-1:0] err_next;
  logic [IW-1:0] fail_next;

  sweep_counter #(.W(IW)) u_counter (
    .clk   (clk),
    .nrst  (nrst),
    .clear (launch),
    .en    (advance),
    .count (idx),
    .last  (idx_last)
  );

  // The index register drives the adder directly: 0 in IDLE, held in DONE.
  assign {A, B, Cin} = idx;

  assign ref_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
  assign mismatch = ({Cout, S} != ref_sum);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    advance    = 1'b0;
    err_next   = err_count;
    fail_next  = first_fail;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = DRIVE;
          launch     = 1'b1;
          err_next   = '0;
          fail_next  = '0;
        end
      end
      DRIVE: state_next = CHECK;
      CHECK: begin
        if (mismatch) begin
          if (err_count == '0) fail_next = idx;
          if (!(&err_count))   err_next  = err_count + 1'b1;
        end
        if (idx_last) begin
          state_next = DONE;
        end else begin
          state_next = DRIVE;
          advance    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered from next-state so they are glitch-free and
  // the final vector's verdict is already in err_count/pass on the first DONE cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      err_count  <= '0;
      first_fail <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_next;
      err_count  <= err_next;
      first_fail <= fail_next;
      busy       <= (state_next == DRIVE) || (state_next == CHECK);
      done       <= (state_next == DONE);
      pass       <= (state_next == DONE) && (err_next == '0);
    end
  end

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Scoreboard bench for adder_sweep_checker: a behavioural adder with selectable
// faults feeds the DUT; expected verdicts are queued at start and popped at done.
module tb_adder_sweep_checker;

  typedef struct {
    int err;
    int ff;
    int cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start4, start1;
  logic [3:0] a4, b4, s4;
  logic       c4, cout4;
  logic       busy4, done4, pass4;
  logic [9:0] err4;
  logic [8:0] ff4;
  logic [0:0] a1, b1, s1;
  logic       c1, cout1;
  logic       busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] ff1;

  int   fault4;
  bit   sel1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  adder_sweep_checker #(.WIDTH(4)) dut4 (
    .clk(clk), .nrst(nrst), .start(start4),
    .A(a4), .B(b4), .Cin(c4), .S(s4), .Cout(cout4),
    .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .first_fail(ff4)
  );

  adder_sweep_checker #(.WIDTH(1)) dut1 (
    .clk(clk), .nrst(nrst), .start(start1),
    .A(a1), .B(b1), .Cin(c1), .S(s1), .Cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1)
  );

  // Fault 0 golden, 1 S[0] stuck 0, 2 Cout stuck 0, 3 every output bit inverted.
  function automatic int faulty_sum(int fault, int w, int a, int b, int c);
    int mask = (1 << (w + 1)) - 1;
    int sum  = a + b + c;
    case (fault)
      1:       sum = sum & ~1;
      2:       sum = sum & ~(1 << w);
      3:       sum = ~sum;
      default: ;
    endcase
    return sum & mask;
  endfunction

  always_comb {cout4, s4} = 5'(faulty_sum(fault4, 4, int'(a4), int'(b4), int'(c4)));
  always_comb {cout1, s1} = 2'(faulty_sum(3, 1, int'(a1), int'(b1), int'(c1)));

  // Walks the sweep in A-outer / B / Cin-inner order against a golden sum.
  function automatic exp_t model_sweep(int fault, int w);
    exp_t e;
    int   n = 1 << (2 * w + 1);
    e.err    = 0;
    e.ff     = 0;
    e.cycles = 2 * n;
    for (int i = 0; i < n; i++) begin
      int a = i >> (w + 1);
      int b = (i >> 1) & ((1 << w) - 1);
      int c = i & 1;
      if (faulty_sum(fault, w, a, b, c) != a + b + c) begin
        if (e.err == 0) e.ff = i;
        e.err++;
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [63:0] o_busy();  return sel1 ? 64'(busy1) : 64'(busy4); endfunction
  function automatic logic [63:0] o_done();  return sel1 ? 64'(done1) : 64'(done4); endfunction
  function automatic logic [63:0] o_pass();  return sel1 ? 64'(pass1) : 64'(pass4); endfunction
  function automatic logic [63:0] o_err();   return sel1 ? 64'(err1)  : 64'(err4);  endfunction
  function automatic logic [63:0] o_ff();    return sel1 ? 64'(ff1)   : 64'(ff4);   endfunction
  function automatic logic [63:0] o_vec();
    return sel1 ? 64'({a1, b1, c1}) : 64'({a4, b4, c4});
  endfunction

  // Counts busy cycles until done; checks the first busy cycle's vector and flags.
  task automatic wait_done(input string tag, input bit hold, output int cycles);
    bit seen = 1'b0;
    bit first = 1'b1;
    cycles = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (!hold) begin
        start4 = 1'b0;
        start1 = 1'b0;
      end
      if (o_busy() == 1) begin
        if (first) begin
          check({tag, " first_vec"}, o_vec(), 0);
          check({tag, " pass_busy"}, o_pass(), 0);
          first = 1'b0;
        end
        cycles++;
      end
      if (o_done() == 1) seen = 1'b1;
    end
    check({tag, " done_seen"}, 64'(seen), 1);
  endtask

  task automatic score(input string tag, input int cycles, input int w);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, " queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " cycles"},     64'(cycles), 64'(e.cycles));
    check({tag, " err_count"},  o_err(),     64'(e.err));
    check({tag, " first_fail"}, o_ff(),      64'(e.ff));
    check({tag, " pass"},       o_pass(),    64'(e.err == 0));
    check({tag, " last_vec"},   o_vec(),     64'((1 << (2 * w + 1)) - 1));
    check({tag, " busy_done"},  o_busy(),    0);
  endtask

  task automatic run_sweep(input string tag, input bit use1, input int fault);
    int cycles;
    int w = use1 ? 1 : 4;
    sel1 = use1;
    exp_q.push_back(model_sweep(fault, w));
    if (use1) begin
      start1 = 1'b1;
    end else begin
      fault4 = fault;
      start4 = 1'b1;
    end
    wait_done(tag, 1'b0, cycles);
    score(tag, cycles, w);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, o_busy(), 0);
    check({tag, " done"}, o_done(), 0);
    check({tag, " pass"}, o_pass(), 0);
    check({tag, " err"},  o_err(),  0);
    check({tag, " ff"},   o_ff(),   0);
    check({tag, " vec"},  o_vec(),  0);
  endtask

  initial begin
    int cycles;
    nrst   = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    fault4 = 0;
    sel1   = 1'b0;
    #7;
    check_all_zero("reset");
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;

    run_sweep("golden", 1'b0, 0);
    run_sweep("s0_stuck", 1'b0, 1);
    // A carry-out fault corrupts exactly the upper half of the sum range.
    run_sweep("cout_stuck", 1'b0, 2);
    run_sweep("all_wrong4", 1'b0, 3);
    run_sweep("all_wrong1", 1'b1, 3);

    // Abort mid-sweep with errors already logged, then sweep again cleanly.
    sel1   = 1'b0;
    fault4 = 1;
    start4 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
    end
    check("mid_sweep err_nonzero", 64'(err4 != 0), 1);
    #2 nrst = 1'b0;
    #1 check_all_zero("async_reset");
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_reset");
    run_sweep("post_reset", 1'b0, 0);

    // start held high: exactly one sweep, then restart right after done.
    fault4 = 3;
    exp_q.push_back(model_sweep(3, 4));
    start4 = 1'b1;
    wait_done("held", 1'b1, cycles);
    score("held", cycles, 4);
    fault4 = 0;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("restart busy", 64'(busy4), 1);
    check("restart done", 64'(done4), 0);
    check("restart err_clear", 64'(err4), 0);
    exp_q.push_back(model_sweep(0, 4));
    wait_done("restart", 1'b0, cycles);
    score("restart", cycles + 1, 4);

    // Verdict must hold steady in DONE while start stays low.
    repeat (5) @(posedge clk);
    #1;
    check("hold done", 64'(done4), 1);
    check("hold pass", 64'(pass4), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
